// File: rtl/panda_wb_pkg.sv
// ----------------------------------------------------------------------------
// panda_wb_pkg
//   Shared Wishbone definitions for the panda interconnect: bus widths, the
//   responder FSM state type and a small saturating-increment helper.
// ----------------------------------------------------------------------------
package panda_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        WBS_IDLE,
        WBS_WAIT,
        WBS_ACK
    } wbs_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage : panda_wb_pkg

// File: rtl/wb_bus_t.sv
// ----------------------------------------------------------------------------
// wb_bus_t
//   Wishbone classic bus bundle.
//   master modport : drives cyc/stb/we/adr/sel/dat_ms and the tag/lock lines,
//                    receives ack/dat_sm.
//   slave  modport : receives cyc/stb/we/adr/sel/dat_ms, drives ack/dat_sm.
//                    Lock and tag lines are not part of the slave view; the
//                    responders in this slice ignore them.
// ----------------------------------------------------------------------------
interface wb_bus_t;
    import panda_wb_pkg::*;

    logic                 wb_cyc;
    logic                 wb_stb;
    logic                 wb_we;
    logic                 wb_lock;
    logic [WB_ADDR_W-1:0] wb_adr;
    logic [WB_SEL_W-1:0]  wb_sel;
    logic [WB_DATA_W-1:0] wb_dat_ms;
    logic [WB_DATA_W-1:0] wb_dat_sm;
    logic                 wb_ack;
    logic                 wb_tgc;
    logic                 wb_tga;
    logic                 wb_tgd_ms;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_lock, wb_adr, wb_sel, wb_dat_ms,
               wb_tgc, wb_tga, wb_tgd_ms,
        input  wb_ack, wb_dat_sm
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
        output wb_ack, wb_dat_sm
    );

endinterface : wb_bus_t

// File: rtl/sp_ram_be.sv
// ----------------------------------------------------------------------------
// sp_ram_be
//   Single-port RAM, DEPTH_WORDS x 32 bit, per-byte write enable, synchronous
//   read (data appears the cycle after rd_en).
//   clk     in   clock
//   rd_en   in   capture mem[addr] into rdata on this edge
//   wr_en   in   write enabled byte lanes of wdata to mem[addr] on this edge
//   be      in   byte-lane enables for writes
//   addr    in   word index
//   wdata   in   write data
//   rdata   out  registered read data
// ----------------------------------------------------------------------------
module sp_ram_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array and its read register have no reset; a reset would force
    // the storage into flops instead of a RAM macro, and contents are undefined
    // after reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (rd_en) rdata <= mem[addr];
    end

endmodule : sp_ram_be

// File: rtl/wb_ram_slave.sv
// ----------------------------------------------------------------------------
// wb_ram_slave
//   Wishbone responder for a word-addressed, byte-writable on-chip RAM.
//   Accepts one request, waits WAIT_STATES cycles, then acks for one cycle.
//   clk       in   clock, rising edge
//   rstn_i    in   asynchronous active-low reset
//   wb_bus    slave modport of wb_bus_t
//   busy_o    out  high while in WAIT or ACK
//   rd_cnt_o  out  saturating count of acked reads   (WB_RAM_STATS_EN only)
//   wr_cnt_o  out  saturating count of acked writes  (WB_RAM_STATS_EN only)
//   Build option: define WB_RAM_STATS_EN to add the statistics counters.
// ----------------------------------------------------------------------------
module wb_ram_slave
    import panda_wb_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rstn_i,
    wb_bus_t.slave      wb_bus,
`ifdef WB_RAM_STATS_EN
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
`endif
    output logic        busy_o
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    wbs_state_t           state_q, state_d;
    logic [3:0]           wcnt_q;
    logic [IDX_W-1:0]     lat_idx;
    logic                 lat_we;
    logic [WB_SEL_W-1:0]  lat_sel;
    logic [WB_DATA_W-1:0] lat_dat;

    logic                 req;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     ram_addr;
    logic                 ram_rd_en;
    logic                 ram_wr_en;
    logic [31:0]          ram_q;

    assign req = wb_bus.wb_cyc & wb_bus.wb_stb;

    // Offset from the base, drop the byte bits, wrap modulo the depth.
    assign cur_idx = IDX_W'((wb_bus.wb_adr - BASE_ADDR) >> 2);

    // NOTE: state and every other register use non-blocking assignments so all
    // flops update together on the edge; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state_q <= WBS_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: state_d takes its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WBS_IDLE: if (req) state_d = (WS != 4'd0) ? WBS_WAIT : WBS_ACK;
            WBS_WAIT: begin
                if (!wb_bus.wb_cyc)      state_d = WBS_IDLE;
                else if (wcnt_q == 4'd1) state_d = WBS_ACK;
            end
            WBS_ACK:  state_d = WBS_IDLE;
            default:  state_d = WBS_IDLE;
        endcase
    end

    // Request latch and wait counter; later bus changes are ignored.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wcnt_q  <= '0;
            lat_idx <= '0;
            lat_we  <= 1'b0;
            lat_sel <= '0;
            lat_dat <= '0;
        end else if (state_q == WBS_IDLE && req) begin
            wcnt_q  <= WS;
            lat_idx <= cur_idx;
            lat_we  <= wb_bus.wb_we;
            lat_sel <= wb_bus.wb_sel;
            lat_dat <= wb_bus.wb_dat_ms;
        end else if (state_q == WBS_WAIT && wb_bus.wb_cyc) begin
            wcnt_q  <= wcnt_q - 4'd1;
        end
    end

    assign wb_bus.wb_ack = (state_q == WBS_ACK) & req;

    // With zero wait states the read is issued on the same edge that latches
    // the request, so the live address must be used while still in IDLE.
    assign ram_addr  = (state_q == WBS_IDLE) ? cur_idx : lat_idx;
    assign ram_rd_en = (state_d == WBS_ACK);
    assign ram_wr_en = wb_bus.wb_ack & lat_we;

    sp_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rd_en (ram_rd_en),
        .wr_en (ram_wr_en),
        .be    (lat_sel),
        .addr  (ram_addr),
        .wdata (lat_dat),
        .rdata (ram_q)
    );

    assign wb_bus.wb_dat_sm = (state_q == WBS_ACK) ? ram_q : '0;
    assign busy_o           = (state_q != WBS_IDLE);

`ifdef WB_RAM_STATS_EN
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (wb_bus.wb_ack) begin
            if (lat_we) wr_cnt_o <= sat_inc(wr_cnt_o);
            else        rd_cnt_o <= sat_inc(rd_cnt_o);
        end
    end
`endif

endmodule : wb_ram_slave

// File: tb/tb_wb_ram_slave.sv
// ----------------------------------------------------------------------------
// tb_wb_ram_slave
//   Three responders with WAIT_STATES = 1, 0 and 3, each on its own bus and
//   reset. Drivers push the expected ack cycle and read data into a per-DUT
//   queue; one monitor pops and compares whenever an ack appears.
// ----------------------------------------------------------------------------
module tb_wb_ram_slave;

    localparam int NDUT = 3;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn   [NDUT];
    logic        cyc    [NDUT];
    logic        stb    [NDUT];
    logic        we     [NDUT];
    logic [31:0] adr    [NDUT];
    logic [3:0]  sel    [NDUT];
    logic [31:0] dat    [NDUT];
    logic        ack_w  [NDUT];
    logic [31:0] dat_w  [NDUT];
    logic        busy_w [NDUT];
`ifdef WB_RAM_STATS_EN
    logic [31:0] rd_cnt_w [NDUT];
    logic [31:0] wr_cnt_w [NDUT];
`endif

    int   checks  = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;
    int   exp_rd [NDUT];
    int   exp_wr [NDUT];
    exp_t q0[$], q1[$], q2[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_bus_t u_bus ();

        assign u_bus.wb_cyc    = cyc[g];
        assign u_bus.wb_stb    = stb[g];
        assign u_bus.wb_we     = we[g];
        assign u_bus.wb_adr    = adr[g];
        assign u_bus.wb_sel    = sel[g];
        assign u_bus.wb_dat_ms = dat[g];
        assign u_bus.wb_lock   = 1'b0;
        assign u_bus.wb_tgc    = 1'b0;
        assign u_bus.wb_tga    = 1'b0;
        assign u_bus.wb_tgd_ms = 1'b0;
        assign ack_w[g]        = u_bus.wb_ack;
        assign dat_w[g]        = u_bus.wb_dat_sm;

        wb_ram_slave #(
            .DEPTH_WORDS (1024),
            .BASE_ADDR   (32'h0),
            .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) u_dut (
            .clk      (clk),
            .rstn_i   (rstn[g]),
            .wb_bus   (u_bus),
`ifdef WB_RAM_STATS_EN
            .rd_cnt_o (rd_cnt_w[g]),
            .wr_cnt_o (wr_cnt_w[g]),
`endif
            .busy_o   (busy_w[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void sb_push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic bit sb_pop(input int d, output exp_t e);
        e = '{cyc: 0, rd: 1'b0, data: 32'h0};
        case (d)
            0: begin if (q0.size() == 0) return 1'b0; e = q0.pop_front(); end
            1: begin if (q1.size() == 0) return 1'b0; e = q1.pop_front(); end
            default: begin if (q2.size() == 0) return 1'b0; e = q2.pop_front(); end
        endcase
        return 1'b1;
    endfunction

    function automatic int sb_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Monitor: every ack must match the head of the queue in cycle and data.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rstn[d]) begin
                if (ack_w[d]) begin
                    if (!sb_pop(d, mon_e)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack dut%0d: got ack in cycle %0d expected none", d, cyc_cnt);
                    end else begin
                        check($sformatf("ack_cycle_dut%0d", d), cyc_cnt, mon_e.cyc);
                        if (mon_e.rd) check($sformatf("rd_data_dut%0d", d), dat_w[d], mon_e.data);
                    end
                end else begin
                    check($sformatf("dat_idle_dut%0d", d), dat_w[d], 32'h0);
                end
            end
        end
    end

    task automatic idle_bus(input int d);
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
        we[d]  = 1'b0;
        adr[d] = 32'h0;
        sel[d] = 4'h0;
        dat[d] = 32'h0;
    endtask

    // Called on a negedge; returns on a negedge after the bus is released.
    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] dt, input logic [31:0] exp_d, input bit scramble);
        exp_t e;
        int   n;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat[d] = dt;
        e.cyc  = cyc_cnt + 1 + ws_of(d);
        e.rd   = !w;
        e.data = exp_d;
        sb_push(d, e);
        if (w) exp_wr[d]++; else exp_rd[d]++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && n == 1) begin
                adr[d] = a ^ 32'h4;
                dat[d] = ~dt;
                sel[d] = ~s;
            end
        end while (!ack_w[d] && n < 40);
        if (!ack_w[d]) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d: got no ack expected ack for adr %h", d, a);
        end
        @(posedge clk);
        #1 idle_bus(d);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        int   c;
        int   n;
        logic [31:0] burst_adr [3];
        logic [31:0] burst_dat [3];
        burst_adr[0] = 32'h0; burst_adr[1] = 32'h4; burst_adr[2] = 32'h8;
        burst_dat[0] = 32'hA0A0_A0A0; burst_dat[1] = 32'hB1B1_B1B1; burst_dat[2] = 32'hC2C2_C2C2;

        for (int d = 0; d < NDUT; d++) begin
            rstn[d] = 1'b0;
            exp_rd[d] = 0;
            exp_wr[d] = 0;
            idle_bus(d);
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_ack_dut%0d", d), 32'(ack_w[d]), 32'h0);
            check($sformatf("rst_dat_dut%0d", d), dat_w[d], 32'h0);
            check($sformatf("rst_busy_dut%0d", d), 32'(busy_w[d]), 32'h0);
        end
        for (int d = 0; d < NDUT; d++) rstn[d] = 1'b1;
        @(negedge clk);

        // ---- WAIT_STATES = 1 ----
        access(0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b1, 32'h10, 4'b0010, 32'h0000_AA00, 32'h0, 1'b0);
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_AAEF, 1'b0);
        access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        access(0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'hDEAD_AAEF, 1'b0);
        // Index wraps modulo 1024 words; adr[1:0] ignored.
        access(0, 1'b1, 32'h1000, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        access(0, 1'b0, 32'h0, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
        access(0, 1'b0, 32'h3, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
        // Bus changes after acceptance must not affect the latched write.
        access(0, 1'b1, 32'h40, 4'b1111, 32'h0102_0304, 32'h0, 1'b1);
        access(0, 1'b0, 32'h40, 4'b1111, 32'h0, 32'h0102_0304, 1'b0);
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_AAEF, 1'b0);

        // ---- WAIT_STATES = 0 ----
        for (int k = 0; k < 3; k++) access(1, 1'b1, burst_adr[k], 4'b1111, burst_dat[k], 32'h0, 1'b0);
        access(1, 1'b0, 32'h4, 4'b1111, 32'h0, 32'hB1B1_B1B1, 1'b0);
        // Strobe held across three reads: acks in cycles c+1, c+3, c+5.
        c = cyc_cnt;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'b1111; adr[1] = burst_adr[0];
        for (int k = 0; k < 3; k++) begin
            e.cyc = c + 1 + 2 * k;
            e.rd = 1'b1;
            e.data = burst_dat[k];
            sb_push(1, e);
            exp_rd[1]++;
        end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ack_w[1] && n < 20);
            if (!ack_w[1]) begin
                checks++;
                errors++;
                $display("FAIL burst_timeout: got no ack expected ack %0d", k);
            end
            if (k < 2) adr[1] = burst_adr[k + 1];
        end
        @(posedge clk);
        #1 idle_bus(1);
        @(negedge clk);

        // ---- WAIT_STATES = 3 ----
        access(2, 1'b1, 32'h20, 4'b1111, 32'h1111_1111, 32'h0, 1'b0);
        access(2, 1'b0, 32'h20, 4'b1111, 32'h0, 32'h1111_1111, 1'b0);
        // Abort in WAIT: no ack, no write.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; sel[2] = 4'b1111; dat[2] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        check("abort_busy_before", 32'(busy_w[2]), 32'h1);
        idle_bus(2);
        repeat (6) @(negedge clk);
        check("abort_busy_after", 32'(busy_w[2]), 32'h0);
        access(2, 1'b0, 32'h20, 4'b1111, 32'h0, 32'h1111_1111, 1'b0);
        // Reset in WAIT: outputs clear immediately, write dropped.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; sel[2] = 4'b1111; dat[2] = 32'h5555_5555;
        @(negedge clk);
        check("rstmid_busy_before", 32'(busy_w[2]), 32'h1);
        rstn[2] = 1'b0;
        #1;
        check("rstmid_ack", 32'(ack_w[2]), 32'h0);
        check("rstmid_dat", dat_w[2], 32'h0);
        check("rstmid_busy", 32'(busy_w[2]), 32'h0);
        idle_bus(2);
        @(negedge clk);
        rstn[2] = 1'b1;
        exp_rd[2] = 0;
        exp_wr[2] = 0;
        @(negedge clk);
        access(2, 1'b0, 32'h20, 4'b1111, 32'h0, 32'h1111_1111, 1'b0);

        repeat (5) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("sb_left_dut%0d", d), 32'(sb_size(d)), 32'h0);
`ifdef WB_RAM_STATS_EN
            check($sformatf("rd_cnt_dut%0d", d), rd_cnt_w[d], 32'(exp_rd[d]));
            check($sformatf("wr_cnt_dut%0d", d), wr_cnt_w[d], 32'(exp_wr[d]));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wb_ram_slave
